// File: rtl/bcd_cnt_pkg.sv
// Shared BCD digit type, digit limits and nibble validity check for the
// N-digit BCD counter.
package bcd_cnt_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic is_valid_bcd(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One registered BCD digit: steps when ci is high, wraps 9->0 up / 0->9 down,
// and raises co when that step rolls over into the next digit.
module bcd_digit
  import bcd_cnt_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       ci,
  input  logic       up_dn,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] q,
  output logic       co
);

  bcd_digit_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = ld_val;
    end else if (ci) begin
      if (up_dn) q_d = (q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1;
      else       q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q  = q_q;
  assign co = ci & (up_dn ? (q_q == BCD_MAX) : (q_q == BCD_MIN));

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with preload, invalid-load flag and cascade
// carry. Define BCD_CNT_SAT_EN for saturating count (carry_out tied low).
module bcd_counter_n
  import bcd_cnt_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    load,
  input  logic [NUM_DIGITS*4-1:0] load_val,
  output logic [NUM_DIGITS*4-1:0] digits,
  output logic                    carry_out,
  output logic                    load_err
);

  logic [NUM_DIGITS:0] chain;
  logic                load_ok;
  logic                step_en;
  logic                load_err_q, load_err_d;

  always_comb begin
    load_ok = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      load_ok = load_ok & is_valid_bcd(load_val[i*4 +: 4]);
    end
  end

`ifdef BCD_CNT_SAT_EN
  logic at_term;

  always_comb begin
    at_term = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      at_term = at_term & (digits[i*4 +: 4] == (up_dn ? BCD_MAX : BCD_MIN));
    end
  end

  // Blocking the step at the terminal value keeps the chain from ever rolling over.
  assign step_en   = en & ~load & ~reset & ~at_term;
  assign carry_out = 1'b0;
`else
  // Gating the chain head makes the last digit's co exactly the cascade carry.
  assign step_en   = en & ~load & ~reset;
  assign carry_out = chain[NUM_DIGITS];
`endif

  assign chain[0] = step_en;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clock  (clock),
      .reset  (reset),
      .ci     (chain[g]),
      .up_dn  (up_dn),
      .ld     (load & load_ok),
      .ld_val (load_val[g*4 +: 4]),
      .q      (digits[g*4 +: 4]),
      .co     (chain[g+1])
    );
  end

  assign load_err_d = load & ~load_ok;

  always_ff @(posedge clock) begin
    if (reset) load_err_q <= 1'b0;
    else       load_err_q <= load_err_d;
  end

  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Scoreboard bench for bcd_counter_n: integer reference model, directed
// scenarios plus random traffic, and extra 1/6-digit and cascaded instances.
module tb_bcd_counter_n;

  localparam int ND  = 3;
  localparam int MOD = 1000;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic            rst, en, ud, ld;
  logic [ND*4-1:0] lv, dg;
  logic            co, le;

  bcd_counter_n #(.NUM_DIGITS(ND)) dut (
    .clock(clk), .reset(rst), .en(en), .up_dn(ud), .load(ld),
    .load_val(lv), .digits(dg), .carry_out(co), .load_err(le)
  );

  // Extra instances share one set of control inputs.
  logic        x_rst, x_en, x_ld;
  logic [23:0] v6, d6;
  logic [3:0]  v1, d1, vhi, dhi;
  logic [7:0]  vlo, dlo;
  logic        c6, c1, clo, chi, e6, e1, elo, ehi;

  bcd_counter_n #(.NUM_DIGITS(6)) u_d6 (
    .clock(clk), .reset(x_rst), .en(x_en), .up_dn(1'b1), .load(x_ld),
    .load_val(v6), .digits(d6), .carry_out(c6), .load_err(e6)
  );
  bcd_counter_n #(.NUM_DIGITS(1)) u_d1 (
    .clock(clk), .reset(x_rst), .en(x_en), .up_dn(1'b1), .load(x_ld),
    .load_val(v1), .digits(d1), .carry_out(c1), .load_err(e1)
  );
  bcd_counter_n #(.NUM_DIGITS(2)) u_lo (
    .clock(clk), .reset(x_rst), .en(x_en), .up_dn(1'b1), .load(x_ld),
    .load_val(vlo), .digits(dlo), .carry_out(clo), .load_err(elo)
  );
  bcd_counter_n #(.NUM_DIGITS(1)) u_hi (
    .clock(clk), .reset(x_rst), .en(clo), .up_dn(1'b1), .load(x_ld),
    .load_val(vhi), .digits(dhi), .carry_out(chi), .load_err(ehi)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the count as a plain integer.
  int m_cnt;
  bit m_lerr;

  typedef struct {
    logic [ND*4-1:0] dg;
    logic            co;
    logic            le;
  } exp_t;
  exp_t sb[$];

  function automatic logic [ND*4-1:0] int2bcd(input int x);
    logic [ND*4-1:0] r;
    int p = 1;
    for (int i = 0; i < ND; i++) begin
      r[i*4 +: 4] = 4'((x / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int bcd2int(input logic [ND*4-1:0] v);
    int s = 0;
    int p = 1;
    for (int i = 0; i < ND; i++) begin
      s = s + int'(v[i*4 +: 4]) * p;
      p = p * 10;
    end
    return s;
  endfunction

  function automatic bit all_valid(input logic [ND*4-1:0] v);
    for (int i = 0; i < ND; i++) if (v[i*4 +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  task automatic stim(input bit r, input bit e, input bit u, input bit l,
                      input logic [ND*4-1:0] v);
    exp_t x;
    bit   term;
    rst = r; en = e; ud = u; ld = l; lv = v;
    term = u ? (m_cnt == MOD - 1) : (m_cnt == 0);
    x.dg = int2bcd(m_cnt);
    x.le = m_lerr;
`ifdef BCD_CNT_SAT_EN
    x.co = 1'b0;
`else
    x.co = e && !l && !r && term;
`endif
    sb.push_back(x);
    if (r) begin
      m_cnt = 0; m_lerr = 0;
    end else if (l) begin
      m_lerr = !all_valid(v);
      if (all_valid(v)) m_cnt = bcd2int(v);
    end else begin
      m_lerr = 0;
      if (e) begin
`ifdef BCD_CNT_SAT_EN
        if (!term) m_cnt = u ? m_cnt + 1 : m_cnt - 1;
`else
        m_cnt = u ? (m_cnt + 1) % MOD : (m_cnt + MOD - 1) % MOD;
`endif
      end
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("digits", 32'(dg), 32'(e.dg));
      chk("carry_out", 32'(co), 32'(e.co));
      chk("load_err", 32'(le), 32'(e.le));
    end
  end

  function automatic logic [ND*4-1:0] rand_lv();
    logic [ND*4-1:0] r;
    case ($urandom_range(0, 5))
      0: r = 12'h999;
      1: r = 12'h000;
      default:
        for (int i = 0; i < ND; i++)
          r[i*4 +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                     : 4'($urandom_range(0, 9));
    endcase
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; en = 0; ud = 0; ld = 0; lv = '0;
    x_rst = 1; x_en = 0; x_ld = 0; v6 = '0; v1 = '0; vlo = '0; vhi = '0;
    @(posedge clk); #1;
    m_cnt = 0; m_lerr = 0;

    // Full up-count sweep through wrap
    stim(1, 0, 0, 0, '0);
    for (int i = 0; i < 1001; i++) stim(0, 1, 1, 0, '0);
    // Load then up across digit rollover, then down
    stim(0, 0, 0, 1, 12'h457);
    for (int i = 0; i < 3; i++) stim(0, 1, 1, 0, '0);
    for (int i = 0; i < 2; i++) stim(0, 1, 0, 0, '0);
    stim(0, 0, 1, 0, '0);
    // Down from zero
    stim(1, 0, 0, 0, '0);
    stim(0, 1, 0, 0, '0);
    stim(0, 0, 0, 0, '0);
    // Invalid load, with and without en
    stim(0, 0, 0, 1, 12'h123);
    stim(0, 0, 1, 1, 12'h4A7);
    stim(0, 0, 1, 0, '0);
    stim(0, 1, 1, 1, 12'h4A7);
    stim(0, 0, 1, 0, '0);
    // Load beats en, reset beats en
    stim(0, 0, 1, 1, 12'h998);
    stim(0, 1, 1, 1, 12'h100);
    stim(1, 1, 1, 0, '0);
    stim(0, 0, 1, 0, '0);
    // Random traffic
    for (int i = 0; i < 3000; i++)
      stim(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
           1'($urandom), ($urandom_range(0, 9) == 0), rand_lv());
    stim(0, 0, 0, 0, '0);
    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    // 6-digit, 1-digit wrap and two-stage cascade
    @(posedge clk); #1;
    x_rst = 0; x_ld = 1; v6 = 24'h999999; v1 = 4'h9; vlo = 8'h99; vhi = 4'h0;
    @(posedge clk); #1;
    x_ld = 0; x_en = 1;
    @(negedge clk);
    chk("d6_max", 32'(d6), 32'h999999);
    chk("d6_carry", 32'(c6), 32'd1);
    chk("d1_max", 32'(d1), 32'h9);
    chk("d1_carry", 32'(c1), 32'd1);
    chk("casc_099", {20'd0, dhi, dlo}, 32'h099);
    chk("casc_lo_carry", 32'(clo), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("d6_wrap", 32'(d6), 32'h000000);
    chk("d6_carry_low", 32'(c6), 32'd0);
    chk("d1_wrap", 32'(d1), 32'h0);
    chk("casc_100", {20'd0, dhi, dlo}, 32'h100);
    chk("casc_lo_carry_low", 32'(clo), 32'd0);
    @(posedge clk); #1;
    x_en = 0;
    @(negedge clk);
    chk("casc_101", {20'd0, dhi, dlo}, 32'h101);
    chk("x_load_err", {28'd0, e6, e1, elo, ehi}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
